// File: rtl/pcm_compander.sv
// pcm_compander: two-stage pipelined segment compander (linear <-> sign/segment/mantissa).
// Stage 1 captures sign, magnitude and segment (compress) or unpacked code fields (expand).
// Stage 2 packs the code or rebuilds the linear sample and drives the output handshake.
module pcm_compander #(
  parameter int unsigned SEG_W     = 3,
  parameter int unsigned MANT_W    = 4,
  parameter int unsigned LIN_W     = 12,
  parameter int unsigned CH_W      = 5,
  parameter int unsigned ROUND_EXP = 0,
  parameter int unsigned INV_MASK  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [LIN_W-1:0]  in_data,
  input  logic [CH_W-1:0]   in_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LIN_W-1:0]  out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic [15:0]       sat_cnt
);

  localparam int unsigned MAG_W  = LIN_W - 1;
  localparam int unsigned CODE_W = 1 + SEG_W + MANT_W;
  localparam logic [CODE_W-1:0] MASK = CODE_W'(INV_MASK);

  logic              s1_full;
  logic              s1_mode;
  logic              s1_sign;
  logic [MAG_W-1:0]  s1_mag;
  logic [SEG_W-1:0]  s1_seg;
  logic [CH_W-1:0]   s1_ch;

  logic              s2_adv;
  logic              accept;

  logic              in_sign;
  logic              in_sat;
  logic [MAG_W-1:0]  in_mag;
  logic [SEG_W-1:0]  in_seg;
  logic [CODE_W-1:0] in_code;

  logic [MANT_W-1:0] c_mant;
  logic [MAG_W-1:0]  e_mag;
  logic [LIN_W-1:0]  result;
  int unsigned       seg_i;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_full || s2_adv;
  assign accept   = in_valid && in_ready;

  // Stage-1 front end: magnitude and leading-one segment, or code field unpacking.
  always_comb begin
    in_sign = 1'b0;
    in_mag  = '0;
    in_seg  = '0;
    in_code = in_data[CODE_W-1:0] ^ MASK;
    in_sat  = (in_data == {1'b1, {MAG_W{1'b0}}});
    if (!in_mode) begin
      in_sign = in_data[LIN_W-1];
      in_mag  = in_sat ? '1 : MAG_W'(in_sign ? -in_data : in_data);
      for (int unsigned i = MANT_W; i < MAG_W; i++) begin
        if (in_mag[i]) in_seg = SEG_W'(i - MANT_W + 1);
      end
    end else begin
      in_sign = in_code[CODE_W-1];
      in_seg  = in_code[CODE_W-2 -: SEG_W];
      in_mag  = MAG_W'(in_code[MANT_W-1:0]);
    end
  end

  // Stage-1 register: loads whenever it can accept, empties when its content moves on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_full <= 1'b0;
      s1_mode <= 1'b0;
      s1_sign <= 1'b0;
      s1_mag  <= '0;
      s1_seg  <= '0;
      s1_ch   <= '0;
    end else if (in_ready) begin
      s1_full <= in_valid;
      if (in_valid) begin
        s1_mode <= in_mode;
        s1_sign <= in_sign;
        s1_mag  <= in_mag;
        s1_seg  <= in_seg;
        s1_ch   <= in_ch;
      end
    end
  end

  // Stage-2 back end: mantissa truncation for compress, segment reconstruction for expand.
  // Expand: leading one at bit seg+MANT_W-1 OR'ed with the shifted mantissa; the rounding
  // bit sits just below the mantissa so it never collides with either.
  always_comb begin
    seg_i  = 32'(s1_seg);
    c_mant = s1_mag[MANT_W-1:0];
    e_mag  = MAG_W'(s1_mag[MANT_W-1:0]);
    if (seg_i != 0) begin
      c_mant = MANT_W'(s1_mag >> (seg_i - 1));
      e_mag  = (MAG_W'(1) << (seg_i + MANT_W - 1)) |
               (MAG_W'(s1_mag[MANT_W-1:0]) << (seg_i - 1));
      if (ROUND_EXP != 0 && seg_i >= 2) e_mag = e_mag | (MAG_W'(1) << (seg_i - 2));
    end
    if (s1_mode) result = s1_sign ? -{1'b0, e_mag} : {1'b0, e_mag};
    else         result = LIN_W'({s1_sign, s1_seg, c_mant} ^ MASK);
  end

  // Stage-2 register: holds its result until downstream takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_full;
      if (s1_full) begin
        out_data <= result;
        out_ch   <= s1_ch;
      end
    end
  end

  // Saturation counter: accepted most-negative compress inputs, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (accept && !in_mode && in_sat && sat_cnt != '1) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pcm_compander.sv
// tb_pcm_compander: three compander instances (defaults, rounded expand, 0x55 line mask)
// share handshake/mode/tag inputs with per-instance data; a scoreboard of model results
// is checked in order at the output, along with hold stability and sat_cnt.
module tb_pcm_compander;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_mode;
  logic [4:0]  in_ch;
  logic        out_ready;
  logic [11:0] idata [3];
  logic        ir    [3];
  logic        ov    [3];
  logic [11:0] od    [3];
  logic [4:0]  och   [3];
  logic [15:0] sc    [3];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [2:0][11:0] d;
    logic [4:0]       ch;
  } exp_t;

  exp_t        sb [$];
  logic [15:0] sat_exp [3];
  logic        rdy_rand;
  logic        rdy_lvl;

  pcm_compander dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in_mode(in_mode),
    .in_data(idata[0]), .in_ch(in_ch), .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od[0]), .out_ch(och[0]), .sat_cnt(sc[0]));

  pcm_compander #(.ROUND_EXP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in_mode(in_mode),
    .in_data(idata[1]), .in_ch(in_ch), .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od[1]), .out_ch(och[1]), .sat_cnt(sc[1]));

  pcm_compander #(.INV_MASK('h55)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .in_mode(in_mode),
    .in_data(idata[2]), .in_ch(in_ch), .out_valid(ov[2]), .out_ready(out_ready),
    .out_data(od[2]), .out_ch(och[2]), .sat_cnt(sc[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_lvl;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int exp_mag(input int seg, input int mant, input bit rnd);
    if (seg == 0) return mant;
    return ((16 + mant) << (seg - 1)) + ((rnd && seg >= 2) ? (1 << (seg - 2)) : 0);
  endfunction

  function automatic logic [11:0] m_expand(input logic [7:0] code, input bit rnd, input logic [7:0] mask);
    logic [7:0] r;
    int mag;
    r   = code ^ mask;
    mag = exp_mag(int'(r[6:4]), int'(r[3:0]), rnd);
    return r[7] ? 12'(-mag) : 12'(mag);
  endfunction

  // Largest positive code whose plain decode does not exceed the magnitude.
  function automatic logic [11:0] m_compress(input logic [11:0] x, input logic [7:0] mask);
    int v, mag, best;
    bit s;
    v    = $signed(x);
    s    = (v < 0);
    mag  = s ? -v : v;
    if (mag > 2047) mag = 2047;
    best = 0;
    for (int c = 0; c < 128; c++) if (exp_mag(c >> 4, c & 15, 1'b0) <= mag) best = c;
    return {4'b0, ({s, 7'(best)} ^ mask)};
  endfunction

  function automatic logic [11:0] model(input int k, input logic m, input logic [11:0] d);
    bit         rnd;
    logic [7:0] mask;
    rnd  = (k == 1);
    mask = (k == 2) ? 8'h55 : 8'h00;
    return m ? m_expand(d[7:0], rnd, mask) : m_compress(d, mask);
  endfunction

  // ---------------- stimulus ----------------
  task automatic send(input logic m, input logic [2:0][11:0] din, input logic [2:0][11:0] dexp,
                      input logic [4:0] c);
    int   n;
    exp_t e;
    n        = 0;
    in_valid = 1'b1;
    in_mode  = m;
    in_ch    = c;
    for (int k = 0; k < 3; k++) idata[k] = din[k];
    while (!ir[0]) begin
      @(negedge clk);
      n++;
      if (n > 2000) begin
        check("in_ready_timeout", 32'(ir[0]), 1);
        in_valid = 1'b0;
        return;
      end
    end
    e.d  = dexp;
    e.ch = c;
    sb.push_back(e);
    for (int k = 0; k < 3; k++)
      if (!m && din[k] == 12'h800 && sat_exp[k] != 16'hFFFF) sat_exp[k]++;
    @(negedge clk);
  endtask

  task automatic send_m(input logic m, input logic [2:0][11:0] din, input logic [4:0] c);
    logic [2:0][11:0] dexp;
    for (int k = 0; k < 3; k++) dexp[k] = model(k, m, din[k]);
    send(m, din, dexp, c);
  endtask

  task automatic send_k(input logic m, input logic [11:0] v, input logic [11:0] e0,
                        input logic [11:0] e1, input logic [4:0] c);
    logic [2:0][11:0] din, dexp;
    for (int k = 0; k < 3; k++) din[k] = v;
    dexp[0] = e0;
    dexp[1] = e1;
    dexp[2] = model(2, m, v);
    send(m, din, dexp, c);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_mode  = 1'($urandom);
    in_ch    = 5'($urandom);
    for (int k = 0; k < 3; k++) idata[k] = 12'($urandom);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  function automatic logic [11:0] rand_lin();
    case ($urandom_range(0, 7))
      0: return 12'h800;
      1: return 12'h7FF;
      2: return 12'($urandom_range(0, 31));
      3: return 12'hFFF;
      default: return 12'($urandom);
    endcase
  endfunction

  task automatic check_sat(input string tag);
    for (int k = 0; k < 3; k++) check($sformatf("%s%0d", tag, k), 32'(sc[k]), 32'(sat_exp[k]));
  endtask

  // ---------------- output monitor ----------------
  logic        held;
  logic [11:0] hold_d [3];
  logic [4:0]  hold_c;

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (ov[0] && out_ready) begin
        held = 1'b0;
        if (sb.size() == 0) begin
          check("spurious_out", 32'(ov[0]), 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          for (int k = 0; k < 3; k++) begin
            check($sformatf("valid%0d", k), 32'(ov[k]), 1);
            check($sformatf("data%0d_ch%0d", k, e.ch), 32'(od[k]), 32'(e.d[k]));
            check($sformatf("tag%0d", k), 32'(och[k]), 32'(e.ch));
          end
        end
      end else if (ov[0]) begin
        if (held) begin
          for (int k = 0; k < 3; k++) check($sformatf("hold_data%0d", k), 32'(od[k]), 32'(hold_d[k]));
          check("hold_tag", 32'(och[0]), 32'(hold_c));
        end
        held = 1'b1;
        for (int k = 0; k < 3; k++) hold_d[k] = od[k];
        hold_c = och[0];
      end else begin
        held = 1'b0;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0][11:0] din, dexp;
    logic [7:0]       raw, mk;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_ch     = '0;
    out_ready = 1'b1;
    rdy_lvl   = 1'b1;
    rdy_rand  = 1'b0;
    held      = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idata[k]   = '0;
      sat_exp[k] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_in_ready", 32'(ir[0]), 1);
    check("rst_out_valid", 32'(ov[0]), 0);
    check("rst_out_data", 32'(od[0]), 0);
    check("rst_out_ch", 32'(och[0]), 0);
    check("rst_sat", 32'(sc[0]), 0);

    // First sample with latency check
    send_k(1'b0, 12'h005, 12'h005, 12'h005, 5'd1);
    in_valid = 1'b0;
    check("lat_cycle1", 32'(ov[0]), 0);
    @(negedge clk);
    check("lat_cycle2", 32'(ov[0]), 1);

    // Directed values, back to back with mixed modes
    send_k(1'b0, 12'h3E8, 12'h06F, 12'h06F, 5'd2);
    send_k(1'b0, 12'hC18, 12'h0EF, 12'h0EF, 5'd3);
    send_k(1'b1, 12'h06F, 12'h3E0, 12'h3F0, 5'd4);
    send_k(1'b1, 12'h085, 12'hFFB, 12'hFFB, 5'd5);
    send_k(1'b1, 12'h080, 12'h000, 12'h000, 5'd6);
    send_k(1'b1, 12'hF00, 12'h000, 12'h000, 5'd7);
    send_k(1'b1, 12'h0FF, 12'h840, 12'h820, 5'd8);
    send_k(1'b0, 12'h7FF, 12'h07F, 12'h07F, 5'd9);
    send_k(1'b0, 12'hFFF, 12'h081, 12'h081, 5'd10);
    send_k(1'b0, 12'h800, 12'h0FF, 12'h0FF, 5'd11);
    drain();
    check("sat_first", 32'(sc[0]), 1);
    check_sat("sat_directed");

    // Randomised mixed traffic under random backpressure and input gaps
    rdy_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      else begin
        for (int k = 0; k < 3; k++) din[k] = rand_lin();
        send_m(1'($urandom), din, 5'($urandom));
      end
    end
    drain();
    rdy_rand = 1'b0;
    rdy_lvl  = 1'b1;
    repeat (2) @(negedge clk);
    check_sat("sat_random");

    // Round trip: expand each code, then compress the linear value back
    for (int c = 0; c < 256; c++) begin
      for (int k = 0; k < 3; k++) din[k] = {4'($urandom), 8'(c)};
      send_m(1'b1, din, 5'(c));
      for (int k = 0; k < 3; k++) begin
        mk      = (k == 2) ? 8'h55 : 8'h00;
        raw     = 8'(c) ^ mk;
        din[k]  = m_expand(8'(c), (k == 1), mk);
        dexp[k] = (raw == 8'h80) ? {4'b0, mk} : 12'(c);
      end
      send(1'b0, din, dexp, 5'(c));
    end
    drain();

    // Scripted backpressure: 10 mixed samples, output stalled for several cycles
    rdy_lvl = 1'b0;
    repeat (2) @(negedge clk);
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          for (int k = 0; k < 3; k++) din[k] = rand_lin();
          send_m(1'(i & 1), din, 5'(i));
        end
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(negedge clk);
        check("bp_in_ready_low", 32'(ir[0]), 0);
        check("bp_in_flight", sb.size(), 2);
        check("bp_head_tag", 32'(och[0]), 0);
        repeat (4) @(negedge clk);
        check("bp_still_stalled", 32'(ir[0]), 0);
        rdy_lvl = 1'b1;
      end
    join
    drain();

    // Saturation counter sticks at all-ones
    while (sat_exp[0] != 16'hFFFF || sat_exp[1] != 16'hFFFF || sat_exp[2] != 16'hFFFF)
      send_k(1'b0, 12'h800, 12'h0FF, 12'h0FF, 5'd31);
    for (int i = 0; i < 8; i++) send_k(1'b0, 12'h800, 12'h0FF, 12'h0FF, 5'd30);
    drain();
    check("sat_hold", 32'(sc[0]), 32'hFFFF);
    check_sat("sat_big");

    // Reset mid-stream with both stages full
    rdy_lvl = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) din[k] = rand_lin();
    send_m(1'b0, din, 5'd20);
    send_m(1'b1, din, 5'd21);
    in_valid = 1'b0;
    check("mid_full_valid", 32'(ov[0]), 1);
    check("mid_full_ready", 32'(ir[0]), 0);
    #1 rst_n = 1'b0;
    sb.delete();
    for (int k = 0; k < 3; k++) sat_exp[k] = '0;
    @(negedge clk);
    check("mid_rst_valid", 32'(ov[0]), 0);
    check("mid_rst_data", 32'(od[0]), 0);
    check("mid_rst_sat", 32'(sc[0]), 0);
    #1 rst_n = 1'b1;
    rdy_lvl = 1'b1;
    @(negedge clk);
    check("mid_rel_ready", 32'(ir[0]), 1);
    check("mid_rel_valid", 32'(ov[0]), 0);
    @(negedge clk);
    send_k(1'b0, 12'hC18, 12'h0EF, 12'h0EF, 5'd22);
    in_valid = 1'b0;
    check("mid_lat1", 32'(ov[0]), 0);
    @(negedge clk);
    check("mid_lat2", 32'(ov[0]), 1);
    drain();
    check_sat("sat_after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pcm_compander.md
# pcm_compander

Parametrised, pipelined segment compander for the voice path; successor to the fixed 8-bit combinational linear→PCM converter. Converts two's-complement linear samples to sign/segment/mantissa PCM codes (compress) or PCM codes back to linear (expand), selected per sample. Sits between the ADC/DAC sample interfaces and the TDM framer, with valid/ready handshakes on both sides and a channel tag carried alongside each sample.

## Interface
- SEG_W, 3: segment field width; 2^SEG_W segments.
- MANT_W, 4: mantissa field width.
- LIN_W, 12: linear sample width, two's complement; must equal 1 + MANT_W + 2^SEG_W - 1. Derived: MAG_W = LIN_W-1, CODE_W = 1+SEG_W+MANT_W.
- CH_W, 5: channel tag width.
- ROUND_EXP, 0: 1 = add half-step midpoint bias on expand.
- INV_MASK, 0: CODE_W-bit XOR mask applied to codes on both paths (0x55 for A-law line coding).
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts sample this cycle.
- in_mode  in  1  0 = compress, 1 = expand.
- in_data  in  LIN_W  compress: linear sample; expand: code in [CODE_W-1:0], upper bits ignored.
- in_ch  in  CH_W  channel tag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  LIN_W  compress: code in [CODE_W-1:0], upper bits 0; expand: linear sample.
- out_ch  out  CH_W  tag of the result.
- sat_cnt  out  16  count of saturated compress inputs, saturating at 0xFFFF.

## Operation
- Compress: sign = in_data[LIN_W-1]; mag = |in_data|. mag = 2^MAG_W (most-negative input) saturates to 2^MAG_W-1 and increments sat_cnt.
- Segment: if mag[MAG_W-1:MANT_W]==0 then seg=0, mant=mag[MANT_W-1:0]; else p = leading-one index (MANT_W..MAG_W-1), seg = p-MANT_W+1, mant = mag[p-1:p-MANT_W] (truncation).
- Code = {sign, seg, mant} ^ INV_MASK.
- Expand: {sign,seg,mant} = code ^ INV_MASK. seg=0: mag = mant. seg≥1: mag = 2^(seg+MANT_W-1) + mant·2^(seg-1), plus 2^(seg-2) when ROUND_EXP=1 and seg≥2. Output = sign ? -mag : mag, LIN_W bits.
- Positive zero and negative zero codes both expand to 0.
- sat_cnt counts only when the saturating sample is accepted (in_valid & in_ready); holds at 0xFFFF.
- Mode, tag and data travel together; mixed modes back-to-back are legal with no bubble.

## Timing
- Two register stages: S1 = sign, magnitude/leading-one index (or unpacked code fields), mode, tag; S2 = packed result driving out_*.
- Latency 2 cycles from accepted input to out_valid with out_ready held high; throughput 1 sample/cycle.
- Stage advances when it is empty or the next stage advances; in_ready = !S1_full | S1_advances; S2 advances when !out_valid | out_ready.
- out_data/out_ch stable while out_valid & !out_ready; no sample dropped or duplicated under any backpressure pattern.
- Maximum samples in flight: 2; with out_ready low, in_ready falls the cycle after both stages fill.
- Reset (any cycle, including mid-stream): out_valid=0, out_data=0, out_ch=0, sat_cnt=0, both stages empty; in-flight samples discarded; in_ready=1 from first cycle after rst_n deasserts.
- in_data/in_mode/in_ch ignored when in_valid=0.

## Test plan
- Compress, defaults: +5 (0x005) -> 0x05; +1000 (0x3E8) -> 0x6F; -1000 (0xC18) -> 0xEF, each 2 cycles after acceptance.
- Saturation: compress 0x800 -> 0xFF, sat_cnt 0->1; 70000 such samples -> sat_cnt holds 0xFFFF.
- Expand: 0x6F -> 0x3E0 (992) with ROUND_EXP=0, 0x3F0 (1008) with ROUND_EXP=1; 0x85 -> 0xFFB (-5); 0x80 -> 0x000.
- Exhaustive round trip: all 256 codes expand then compress -> original code, with INV_MASK=0 and 0x55.
- Backpressure: stream 10 mixed-mode samples, tags 0..9, out_ready low cycles 3-7 -> in_ready low after 2 held, outputs in order, tags match, none lost.
- Reset mid-stream with both stages full -> out_valid 0 next cycle, sat_cnt 0, subsequent sample emerges after 2 cycles with correct value.
